// File: rtl/approx_smag_mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// approx_smag_mul_seq_pkg
//   Shared definitions for the iterative sign-magnitude approximate multiplier:
//   FSM state encoding, the approximate 3x3 tile value, and a helper that sizes
//   the digit counter from the operand width.
// ---------------------------------------------------------------------------
package approx_smag_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Approximate tiles return 7 instead of 9 for 3x3.
  localparam logic [2:0] APPROX_3X3 = 3'd7;

  // Width of the digit counter for a WIDTH-bit magnitude (WIDTH/2 digits).
  // Never narrower than one bit so the counter stays a real signal at WIDTH=2.
  function automatic int cnt_width(input int width);
    int n;
    n = width / 2;
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/approx_smag_mul_seq_mul2x2.sv
// ---------------------------------------------------------------------------
// approx_mul2x2
//   Combinational 2x2-bit tile multiplier. Exact except when approx is set and
//   both digits are 3, where it returns 7.
// Ports
//   a, b    in   2-bit digits
//   approx  in   enable the approximate 3x3 result
//   p       out  4-bit tile product
// ---------------------------------------------------------------------------
module approx_mul2x2
  import approx_smag_mul_seq_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       approx,
  output logic [3:0] p
);

  always_comb begin
    if (approx && (a == 2'd3) && (b == 2'd3)) p = {1'b0, APPROX_3X3};
    else                                       p = {2'b00, a} * {2'b00, b};
  end

endmodule

// File: rtl/approx_smag_mul_seq.sv
// ---------------------------------------------------------------------------
// approx_smag_mul_seq
//   Iterative sign-magnitude multiplier. Multiplies the latched multiplicand by
//   one 2-bit digit of the multiplier per cycle using a row of 2x2 tiles; tiles
//   near the least-significant corner (digit index sum < APPROX_DIAG) may be
//   approximate when approx_en was set at accept time.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, asign, bsign, approx_en)
//   out_valid/out_ready result handshake (m, sign); result held until taken
// ---------------------------------------------------------------------------
module approx_smag_mul_seq
  import approx_smag_mul_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_DIAG = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               asign,
  input  logic               bsign,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] m,
  output logic               sign
);

  localparam int N  = WIDTH / 2;
  localparam int CW = cnt_width(WIDTH);
  localparam int AW = 2 * WIDTH;
  localparam int RW = WIDTH + 2;   // a * (one 2-bit digit) fits here

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             asign_q, bsign_q, approx_q;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;

  logic             accept;
  logic [1:0]       b_digit;
  logic [3:0]       tile_p [N];
  logic [RW-1:0]    row;
  logic [AW-1:0]    acc_next;

  // in_ready depends on out_ready so a result can be taken and a new operand
  // accepted on the same edge.
  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign b_digit = 2'(b_q >> {cnt, 1'b0});

  for (genvar j = 0; j < N; j++) begin : g_tile
    logic tile_approx;
    assign tile_approx = approx_q && ((int'(cnt) + j) < APPROX_DIAG);

    approx_mul2x2 u_tile (
      .a      (a_q[2*j +: 2]),
      .b      (b_digit),
      .approx (tile_approx),
      .p      (tile_p[j])
    );
  end

  // NOTE: every variable assigned in always_comb gets a default first so no
  // latch is inferred on any path.
  always_comb begin
    row = '0;
    for (int j = 0; j < N; j++) row = row + (RW'(tile_p[j]) << (2 * j));
  end

  assign acc_next = acc + (AW'(row) << {cnt, 1'b0});

  // NOTE: all state updates are non-blocking so every register samples the
  // pre-edge values; operand registers are reset too, so nothing from an
  // aborted operation can leak into a later result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      asign_q   <= 1'b0;
      bsign_q   <= 1'b0;
      approx_q  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      m         <= '0;
      sign      <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            m         <= acc_next;
            sign      <= (asign_q ^ bsign_q) && (acc_next != '0);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: ;
      endcase

      // Accept overrides the DONE->IDLE move when a new operand arrives in
      // the same cycle the result is taken.
      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        asign_q  <= asign;
        bsign_q  <= bsign;
        approx_q <= approx_en;
        acc      <= '0;
        cnt      <= '0;
        state    <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_approx_smag_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_approx_smag_mul_seq
//   Drives two instances (APPROX_DIAG=2 and APPROX_DIAG=7) with the same
//   operands and compares both against a digit-by-digit arithmetic model.
// ---------------------------------------------------------------------------
module tb_approx_smag_mul_seq;

  localparam int W = 8;
  localparam int N = W / 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, out_ready;
  logic [W-1:0]   a, b;
  logic           asign, bsign, approx_en;
  logic           in_ready, out_valid, sign;
  logic [2*W-1:0] m;
  logic           in_ready7, out_valid7, sign7;
  logic [2*W-1:0] m7;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  approx_smag_mul_seq #(.WIDTH(W), .APPROX_DIAG(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .asign(asign), .bsign(bsign), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready), .m(m), .sign(sign)
  );

  approx_smag_mul_seq #(.WIDTH(W), .APPROX_DIAG(7)) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready7),
    .a(a), .b(b), .asign(asign), .bsign(bsign), .approx_en(approx_en),
    .out_valid(out_valid7), .out_ready(out_ready), .m(m7), .sign(sign7)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sum of all digit-pair products, each weighted by 4^(i+j).
  function automatic longint model_m(input int av, input int bv, input bit ap, input int diag);
    longint s = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int da = (av >> (2 * j)) & 3;
        int db = (bv >> (2 * i)) & 3;
        int t  = (ap && (i + j) < diag && da == 3 && db == 3) ? 7 : da * db;
        s += longint'(t) << (2 * (i + j));
      end
    return s;
  endfunction

  function automatic bit model_s(input bit sa, input bit sb, input longint mv);
    return (sa ^ sb) && (mv != 0);
  endfunction

  // Present operands at a negedge and hold in_valid through the accept edge.
  task automatic present(input int av, input int bv, input bit sa, input bit sb, input bit ap);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    check("in_ready_before_accept", in_ready, 1);
    a = W'(av); b = W'(bv); asign = sa; bsign = sb; approx_en = ap;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs during RUN; the latched operands must be used.
    a = W'($urandom); b = W'($urandom); asign = $urandom_range(0, 1);
    bsign = $urandom_range(0, 1); approx_en = $urandom_range(0, 1);
  endtask

  // Wait (bounded) for out_valid after an accept edge; check latency and values.
  task automatic collect(input int av, input int bv, input bit sa, input bit sb, input bit ap,
                         output longint got_m, output bit got_s, output longint got_m7);
    int cyc = 0;
    longint e2, e7;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("latency", cyc, N);
    check("out_valid7", out_valid7, 1);
    e2 = model_m(av, bv, ap, 2);
    e7 = model_m(av, bv, ap, 7);
    check("m_diag2", m, e2);
    check("sign_diag2", sign, model_s(sa, sb, e2));
    check("m_diag7", m7, e7);
    check("sign_diag7", sign7, model_s(sa, sb, e7));
    check("in_ready_done_blocked", in_ready, 0);
    got_m = m; got_s = sign; got_m7 = m7;
  endtask

  task automatic take();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("out_valid_after_take", out_valid, 0);
  endtask

  task automatic run_op(input int av, input int bv, input bit sa, input bit sb, input bit ap,
                        output longint got_m, output bit got_s, output longint got_m7);
    present(av, bv, sa, sb, ap);
    collect(av, bv, sa, sb, ap, got_m, got_s, got_m7);
    take();
  endtask

  initial begin
    longint gm, gm7, hm;
    bit     gs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; asign = 1'b0; bsign = 1'b0; approx_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_m", m, 0);
    check("reset_sign", sign, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;

    // Exact full-scale.
    run_op(255, 255, 0, 0, 0, gm, gs, gm7);
    check("exact_255x255", gm, 65025);
    check("exact_255x255_sign", gs, 0);
    // All tiles approximate on the DIAG=7 instance.
    run_op(255, 255, 0, 0, 1, gm, gs, gm7);
    check("approx_all_255x255", gm7, 50575);
    // Single tile.
    run_op(3, 3, 0, 0, 1, gm, gs, gm7);
    check("approx_3x3", gm, 7);
    run_op(3, 3, 0, 0, 0, gm, gs, gm7);
    check("exact_3x3", gm, 9);
    run_op(12, 3, 0, 0, 1, gm, gs, gm7);
    check("approx_12x3", gm, 28);
    // Sign handling.
    run_op(5, 6, 1, 0, 0, gm, gs, gm7);
    check("signed_5x6", gm, 30);
    check("signed_5x6_sign", gs, 1);
    run_op(0, 9, 1, 0, 0, gm, gs, gm7);
    check("zero_m", gm, 0);
    check("zero_no_neg", gs, 0);

    // Handshake: hold the result, then take it while accepting a new operand.
    present(200, 77, 1, 1, 1);
    collect(200, 77, 1, 1, 1, gm, gs, gm7);
    hm = gm;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      check("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_m", m, hm);
    end
    @(negedge clk);
    a = 8'd173; b = 8'd99; asign = 1'b0; bsign = 1'b1; approx_en = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("take_and_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    a = W'($urandom); b = W'($urandom);
    collect(173, 99, 0, 1, 1, gm, gs, gm7);
    take();

    // Reset mid-operation.
    present(91, 45, 1, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_m", m, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("no_stale_result", seen, 0);
    end

    // Randomized operands.
    for (int t = 0; t < 40; t++) begin
      int  av, bv;
      bit  sa, sb, ap;
      av = (t % 9 == 0) ? 0 : int'($urandom_range(0, 255));
      bv = (t % 11 == 5) ? 255 : int'($urandom_range(0, 255));
      sa = $urandom_range(0, 1); sb = $urandom_range(0, 1); ap = $urandom_range(0, 1);
      run_op(av, bv, sa, sb, ap, gm, gs, gm7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
